lfa_pipe_adder: RTL

// - Parametrised, pipelined Ladner-Fischer prefix adder; successor to the fixed 16b combinational LFA.
// - Adds a valid/ready stream interface, configurable width and pipeline depth.
// - Adds a per-operation Lower-part-OR approximate mode for ALS error/energy studies.
// - Sits between the dataset-driven stimulus harness and the output logger in the ALS benchmark flow.

---
 rtl/lfa_pipe_adder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/lfa_pipe_adder.sv
// -----------------------------------------------------------------------------
// lfa_pipe_adder
//
// Pipelined Ladner-Fischer (fan-out doubling) prefix adder with a valid/ready
// stream interface and a per-operation lower-part-OR approximate mode.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous, active-high reset
//   in_valid   in   1        in0/in1/approx_en valid this cycle
//   in_ready   out  1        block can accept this cycle
//   in0        in   WIDTH    operand A, unsigned
//   in1        in   WIDTH    operand B, unsigned
//   approx_en  in   1        1 = LOA approximate sum for this operation
//   out_valid  out  1        out0 holds a result
//   out_ready  in   1        consumer takes out0 this cycle
//   out0       out  WIDTH+1  sum, MSB is carry-out
//   op_count   out  32       results delivered (out_valid & out_ready), wraps
//
// Datapath: level 0 forms g/p/h per bit, levels 1..log2(WIDTH) are the prefix
// tree, and the sum is h ^ carry. Register cuts are placed after level 0 and
// at evenly spaced prefix levels; the final register always holds the sum.
// -----------------------------------------------------------------------------
module lfa_pipe_adder #(
  parameter int WIDTH       = 16,
  parameter int PIPE        = 2,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out0,
  output logic [31:0]      op_count
);

  localparam int LVLS  = $clog2(WIDTH);
  localparam int DENOM = (PIPE > 1) ? (PIPE - 1) : 1;

  // True when a pipeline register sits directly after prefix level lvl.
  // Stage s (1..PIPE-1) sits after level (s-1)*LVLS/(PIPE-1), so stage 1 is
  // always right after the g/p formation.
  function automatic bit is_cut(input int lvl);
    bit hit;
    hit = 1'b0;
    for (int s = 1; s < PIPE; s++) begin
      if (((s - 1) * LVLS) / DENOM == lvl) hit = 1'b1;
    end
    return hit;
  endfunction

  // One Ladner-Fischer level: bits whose (lvl-1) bit is set absorb the group
  // ending just below their aligned block of size 2^(lvl-1).
  function automatic logic [WIDTH-1:0] lf_g(input logic [WIDTH-1:0] g,
                                            input logic [WIDTH-1:0] p,
                                            input int lvl);
    logic [WIDTH-1:0] r;
    int j;
    r = g;
    for (int i = 0; i < WIDTH; i++) begin
      if (((i >> (lvl - 1)) & 1) == 1) begin
        j    = ((i >> (lvl - 1)) << (lvl - 1)) - 1;
        r[i] = g[i] | (p[i] & g[j]);
      end
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] lf_p(input logic [WIDTH-1:0] p,
                                            input int lvl);
    logic [WIDTH-1:0] r;
    int j;
    r = p;
    for (int i = 0; i < WIDTH; i++) begin
      if (((i >> (lvl - 1)) & 1) == 1) begin
        j    = ((i >> (lvl - 1)) << (lvl - 1)) - 1;
        r[i] = p[i] & p[j];
      end
    end
    return r;
  endfunction

  logic             adv;
  logic             out_valid_q;
  logic [WIDTH:0]   out0_q;
  logic [WIDTH:0]   out0_d;
  logic [31:0]      op_count_q;

  // Global stall: every stage moves together whenever the output slot frees.
  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  // Per-level outputs (0..LVLS-1) and inputs after the optional cut (1..LVLS).
  logic [WIDTH-1:0] g_out [0:LVLS-1];
  logic [WIDTH-1:0] p_out [0:LVLS-1];
  logic [WIDTH-1:0] h_out [0:LVLS-1];
  logic             v_out [0:LVLS-1];
  logic [WIDTH-1:0] g_in  [1:LVLS];
  logic [WIDTH-1:0] p_in  [1:LVLS];
  logic [WIDTH-1:0] h_in  [1:LVLS];
  logic             v_in  [1:LVLS];

  // Level 0. In approximate mode the low part is reshaped so the exact tree
  // does the rest: h = a|b gives the OR bits, all low g/p are zero except
  // g[K-1] = a&b, which becomes the carry into bit K. Carries into the low
  // bits are then zero, so sum = h there.
  logic [WIDTH-1:0] g0_c, p0_c, h0_c;
  always_comb begin
    g0_c = in0 & in1;
    p0_c = in0 ^ in1;
    h0_c = in0 ^ in1;
    if (approx_en) begin
      for (int i = 0; i < APPROX_BITS; i++) begin
        h0_c[i] = in0[i] | in1[i];
        p0_c[i] = 1'b0;
        if (i != APPROX_BITS - 1) g0_c[i] = 1'b0;
      end
    end
  end

  assign g_out[0] = g0_c;
  assign p_out[0] = p0_c;
  assign h_out[0] = h0_c;
  assign v_out[0] = in_valid;

  genvar gi;
  generate
    for (gi = 1; gi < LVLS; gi++) begin : level
      assign g_out[gi] = lf_g(g_in[gi], p_in[gi], gi);
      assign p_out[gi] = lf_p(p_in[gi], gi);
      assign h_out[gi] = h_in[gi];
      assign v_out[gi] = v_in[gi];
    end

    for (gi = 0; gi < LVLS; gi++) begin : feed
      if (is_cut(gi)) begin : cut
        logic [WIDTH-1:0] g_q, p_q, h_q;
        logic             v_q;
        // Only the valid needs clearing; data behind a cleared valid is ignored.
        always_ff @(posedge clk) begin
          if (rst) begin
            v_q <= 1'b0;
          end else if (adv) begin
            v_q <= v_out[gi];
            g_q <= g_out[gi];
            p_q <= p_out[gi];
            h_q <= h_out[gi];
          end
        end
        assign g_in[gi+1] = g_q;
        assign p_in[gi+1] = p_q;
        assign h_in[gi+1] = h_q;
        assign v_in[gi+1] = v_q;
      end else begin : thru
        assign g_in[gi+1] = g_out[gi];
        assign p_in[gi+1] = p_out[gi];
        assign h_in[gi+1] = h_out[gi];
        assign v_in[gi+1] = v_out[gi];
      end
    end
  endgenerate

  // Final level plus sum. Carry into bit i is the group generate of bits
  // i-1..0; carry into bit 0 is zero.
  logic [WIDTH-1:0] g_fin;
  assign g_fin  = lf_g(g_in[LVLS], p_in[LVLS], LVLS);
  assign out0_d = {g_fin[WIDTH-1], h_in[LVLS] ^ {g_fin[WIDTH-2:0], 1'b0}};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out0_q      <= '0;
      op_count_q  <= '0;
    end else begin
      if (adv) begin
        out_valid_q <= v_in[LVLS];
        out0_q      <= out0_d;
      end
      if (out_valid_q & out_ready) op_count_q <= op_count_q + 32'd1;
    end
  end

  assign out_valid = out_valid_q;
  assign out0      = out0_q;
  assign op_count  = op_count_q;

endmodule
